uart_frame_assembler: RTL and testbench
=======================================

// Module: uart_frame_assembler
// PURPOSE
//  Consumes the byte stream from the UART receiver and assembles it into one parallel frame of
//  N unsigned WIDTH-bit elements for the bitonic sorter. Each frame is header-delimited and timed out on stalls.
//  Sits between UART RX (rx_data/rx_valid, 1-cycle pulse per byte) and the sorter input (valid/ready).
// PARAMETERS
//  N            8                        number of elements per frame (>=1)
//  WIDTH        16                       bits per element; multiple of 8, >=8
//  HDR          8'hA5                    frame-start header byte
//  TIMEOUT_CYC  (100_000_000/115200)*20  max idle clk cycles between bytes inside a frame
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous, active-high reset
//  rx_data      in   8        received byte from UART RX
//  rx_valid     in   1        1-cycle strobe: rx_data valid
//  frame_data   out  N*WIDTH  element k at [k*WIDTH +: WIDTH]
//  frame_valid  out  1        frame_data holds a complete frame
//  frame_ready  in   1        downstream accepts frame when frame_valid && frame_ready
//  busy         out  1        high whenever state != IDLE
//  err_timeout  out  1        1-cycle pulse: partial frame discarded on inter-byte timeout
//  err_overrun  out  1        1-cycle pulse: byte dropped while a frame was held
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain. All outputs are registered.
//  - Reset (sync, active-high) clears state to IDLE, counters to 0, and frame_data to 0.
//  - Reset also clears frame_valid, busy, err_timeout and err_overrun to 0. Reset mid-frame discards partial data.
//  - BYTES = N*WIDTH/8. byte_cnt counts 0..BYTES-1, width $clog2(BYTES+1).
//  - gap_cnt width is $clog2(TIMEOUT_CYC+1).
//  IDLE
//  - rx_valid with rx_data==HDR -> COLLECT; byte_cnt=0, gap_cnt=0.
//  - Any other byte is silently discarded; no error is flagged.
//  COLLECT
//  - On rx_valid, the byte is written to frame_data[byte_cnt*8 +: 8]. Ordering is little-endian:
//    first byte is the LSB of element 0, and element 0 fills first.
//  - HDR-valued bytes inside a frame are ordinary data.
//  - The last byte (byte_cnt==BYTES-1) moves the FSM to HOLD.
//  - frame_valid rises the cycle after that rx_valid (latency 1).
//  - gap_cnt clears on every rx_valid and otherwise increments.
//  - When gap_cnt reaches TIMEOUT_CYC-1 with no rx_valid: err_timeout pulses for 1 cycle, FSM -> IDLE,
//    byte_cnt=0. Partial frame_data contents are don't-care.
//  - rx_valid in the timeout cycle takes priority: the byte is accepted and there is no timeout.
//  HOLD
//  - frame_valid=1; frame_data is stable until the handshake.
//  - No timeout counting in HOLD.
//  - frame_valid && frame_ready -> frame_valid=0 next cycle, FSM -> IDLE.
//  - rx_valid while in HOLD with no handshake: byte dropped, err_overrun pulses the next cycle.
//  - Handshake cycle coincident with rx_valid:
//    - rx_data==HDR: FSM goes directly to COLLECT (byte_cnt=0); no overrun.
//    - Otherwise: byte dropped, err_overrun pulses.
//  - frame_valid must never deassert without a handshake, except on rst.
// TESTING  (override N=4, WIDTH=16, TIMEOUT_CYC=100; bytes spaced >=10 clk)
//  1. Send A5,01,00,02,00,03,00,04,00 -> frame_valid high 1 clk after last rx_valid;
//     frame_data=64'h0004_0003_0002_0001; ready=1 -> frame_valid low next clk, busy low.
//  2. Send 00,FF,12, then the frame from test 1 -> garbage ignored, identical frame_data, no err pulses.
//  3. Complete frame with frame_ready=0 for 50 clk; send 33,44 during hold -> err_overrun pulses twice;
//     frame_data unchanged; ready=1 -> accepted.
//  4. Send A5,11,22,33, then idle 120 clk -> exactly one err_timeout pulse 100 clk after byte 33, busy low;
//     next full frame assembles correctly.
//  5. Raise frame_ready in the same cycle rx_valid carries A5, then send 8 data bytes ->
//     second frame delivered, err_overrun never asserts.
//  6. Assert rst for 1 clk after A5 + 5 data bytes -> all outputs 0 next clk; fresh full frame assembles correctly.

Source files
------------

// File: rtl/uart_frame_assembler.sv
// UART byte stream to parallel frame assembler.
// Header-delimited frames, inter-byte timeout, held until handshake.
module uart_frame_assembler #(
  parameter int          N           = 8,
  parameter int          WIDTH       = 16,
  parameter logic [7:0]  HDR         = 8'hA5,
  parameter int          TIMEOUT_CYC = (100_000_000 / 115200) * 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [N*WIDTH-1:0]   frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  localparam int BYTES = N * WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);
  localparam int GW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic          is_hdr;

  assign is_hdr = rx_valid && (rx_data == HDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_hdr) begin
            state    <= COLLECT;
            busy     <= 1'b1;
            byte_cnt <= '0;
            gap_cnt  <= '0;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            for (int i = 0; i < BYTES; i++) begin
              if (byte_cnt == CW'(i))
                frame_data[i*8 +: 8] <= rx_data;
            end
            gap_cnt <= '0;
            if (byte_cnt == CW'(BYTES - 1)) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
              byte_cnt    <= '0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end else if (gap_cnt == GW'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        HOLD: begin
          // frame_valid is always high here, so ready alone completes it
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (is_hdr) begin
              state    <= COLLECT;
              byte_cnt <= '0;
              gap_cnt  <= '0;
            end else begin
              state       <= IDLE;
              busy        <= 1'b0;
              err_overrun <= rx_valid;
            end
          end else if (rx_valid) begin
            err_overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler.
// N=4, WIDTH=16, TIMEOUT_CYC=100.
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic        err_overrun;

  int n_chk = 0;
  int n_pass = 0;
  int to_cnt = 0;
  int ov_cnt = 0;
  int k;
  logic [7:0] fb [8];

  always #5 clk = ~clk;

  uart_frame_assembler #(
    .N(4),
    .WIDTH(16),
    .HDR(8'hA5),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always @(negedge clk) begin
    if (err_timeout) to_cnt++;
    if (err_overrun) ov_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input string tag);
    send(8'hA5);
    for (int i = 0; i < 7; i++) send(fb[i]);
    check({tag, "_fv_pre"}, 64'(frame_valid), 64'd0);
    @(negedge clk);
    rx_data = fb[7];
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check({tag, "_fv"}, 64'(frame_valid), 64'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    check({tag, "_fv_done"}, 64'(frame_valid), 64'd0);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_fv", 64'(frame_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", frame_data, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic frame
    fb = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    send_frame("t1");
    check("t1_data", frame_data, 64'h0004_0003_0002_0001);
    check("t1_busy", 64'(busy), 64'd1);
    accept("t1");

    // garbage before header is ignored
    send(8'h00);
    send(8'hFF);
    send(8'h12);
    check("t2_busy_idle", 64'(busy), 64'd0);
    send_frame("t2");
    check("t2_data", frame_data, 64'h0004_0003_0002_0001);
    accept("t2");
    check("t2_errs", 64'(to_cnt + ov_cnt), 64'd0);

    // overrun while holding
    fb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    send_frame("t3");
    repeat (50) @(negedge clk);
    check("t3_fv_held", 64'(frame_valid), 64'd1);
    send(8'h33);
    send(8'h44);
    check("t3_ov", 64'(ov_cnt), 64'd2);
    check("t3_data", frame_data, 64'h8070_6050_4030_2010);
    check("t3_fv_still", 64'(frame_valid), 64'd1);
    accept("t3");

    // inter-byte timeout
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    rx_data = 8'h33;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        k = i;
        break;
      end
    end
    check("t4_to_delay", 64'(k), 64'd100);
    check("t4_busy", 64'(busy), 64'd0);
    repeat (25) @(negedge clk);
    check("t4_to_cnt", 64'(to_cnt), 64'd1);
    fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame("t4");
    check("t4_data", frame_data, 64'h0807_0605_0403_0201);
    accept("t4");

    // handshake coincident with a new header
    send_frame("t5a");
    @(negedge clk);
    frame_ready = 1'b1;
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    rx_valid = 1'b0;
    check("t5_fv_hs", 64'(frame_valid), 64'd0);
    check("t5_busy_hs", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    fb = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h01, 8'h80, 8'hFF, 8'h00};
    for (int i = 0; i < 7; i++) send(fb[i]);
    @(negedge clk);
    rx_data = fb[7];
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("t5_fv", 64'(frame_valid), 64'd1);
    check("t5_data", frame_data, 64'h00FF_8001_3CC3_5AA5);
    check("t5_ov", 64'(ov_cnt), 64'd2);
    accept("t5");

    // reset mid-frame
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_fv", 64'(frame_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_data", frame_data, 64'd0);
    check("t6_errs", 64'(err_timeout | err_overrun), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34, 8'h12, 8'h78, 8'h56};
    send_frame("t6");
    check("t6_data2", frame_data, 64'h5678_1234_DEAD_BEEF);
    accept("t6");
    check("final_to", 64'(to_cnt), 64'd1);
    check("final_ov", 64'(ov_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
